// File: rtl/ysyx_idu_pipe_if.sv
// ysyx_idu_pipe_if: IFU->IDU and IDU->EXU handshake/bundle signals.
// The slave modport is the decode stage; the master modport is its environment.
interface ysyx_idu_pipe_if #(
    parameter int XLEN = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic             out_rf_wr_en;
    logic [1:0]       out_rf_wr_sel;
    logic             out_alu_a_sel;
    logic             out_alu_b_sel;
    logic [4:0]       out_alu_ctrl;
    logic             out_word;
    logic [2:0]       out_dm_rd_sel;
    logic [2:0]       out_dm_wr_sel;
    logic [2:0]       out_br_type;
    logic             out_jump;
    logic             out_ebreak;
    logic             out_ecall;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_rf_wr_en, out_rf_wr_sel, out_alu_a_sel, out_alu_b_sel,
               out_alu_ctrl, out_word, out_dm_rd_sel, out_dm_wr_sel,
               out_br_type, out_jump, out_ebreak, out_ecall, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_rf_wr_en, out_rf_wr_sel, out_alu_a_sel, out_alu_b_sel,
               out_alu_ctrl, out_word, out_dm_rd_sel, out_dm_wr_sel,
               out_br_type, out_jump, out_ebreak, out_ecall, out_illegal
    );
endinterface

// File: rtl/ysyx_idu_pipe.sv
// ysyx_idu_pipe: RV32I/RV64I decode stage with a 2-entry skid buffer.
// Optional M-extension decode is enabled by defining YSYX_IDU_RVM_EN.
//
// state    | meaning
// ST_EMPTY | M and S invalid
// ST_ONE   | M valid, S invalid
// ST_FULL  | M and S valid, in_ready low
module ysyx_idu_pipe #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    ysyx_idu_pipe_if.slave   bus
);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd14;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rf_wr_en;
        logic [1:0]      rf_wr_sel;
        logic            alu_a_sel;
        logic            alu_b_sel;
        logic [4:0]      alu_ctrl;
        logic            word;
        logic [2:0]      dm_rd_sel;
        logic [2:0]      dm_wr_sel;
        logic [2:0]      br_type;
        logic            jump;
        logic            ebreak;
        logic            ecall;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    logic [31:0]     w_inst;
    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [4:0]      w_alu_rr;
    bundle_t         w_dec;
    logic            w_bad;
    logic            w_wr;

    state_t          r_state, w_state_nxt;
    bundle_t         r_m, r_s;
    logic            w_m_vld, w_in_ready, w_xfer_in, w_xfer_out;
    logic            w_ld_m_in, w_ld_m_s, w_ld_s_in;

    assign w_inst  = bus.in_inst;
    assign w_op    = w_inst[6:0];
    assign w_f3    = w_inst[14:12];
    assign w_f7    = w_inst[31:25];
    assign w_imm_i = XLEN'($signed(w_inst[31:20]));
    assign w_imm_s = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
    assign w_imm_b = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({w_inst[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));

    // Register-register ALU op for funct7=0, indexed by funct3
    always_comb begin
        w_alu_rr = ALU_ADD;
        case (w_f3)
            3'd0: w_alu_rr = ALU_ADD;
            3'd1: w_alu_rr = ALU_SLL;
            3'd2: w_alu_rr = ALU_SLT;
            3'd3: w_alu_rr = ALU_SLTU;
            3'd4: w_alu_rr = ALU_XOR;
            3'd5: w_alu_rr = ALU_SRL;
            3'd6: w_alu_rr = ALU_OR;
            3'd7: w_alu_rr = ALU_AND;
            default: w_alu_rr = ALU_ADD;
        endcase
    end

    // Combinational instruction decode into a control bundle
    always_comb begin
        w_dec    = '0;
        w_bad    = 1'b0;
        w_wr     = 1'b0;
        w_dec.pc = bus.in_pc;
        case (w_op)
            7'h37: begin                                   // lui
                w_dec.imm = w_imm_u; w_dec.rd = w_inst[11:7]; w_wr = 1'b1;
                w_dec.rf_wr_sel = 2'b10; w_dec.alu_b_sel = 1'b1; w_dec.alu_ctrl = ALU_PASSB;
            end
            7'h17: begin                                   // auipc
                w_dec.imm = w_imm_u; w_dec.rd = w_inst[11:7]; w_wr = 1'b1;
                w_dec.rf_wr_sel = 2'b10; w_dec.alu_b_sel = 1'b1; w_dec.alu_ctrl = ALU_ADD;
            end
            7'h6F: begin                                   // jal: ALU forms pc+imm
                w_dec.imm = w_imm_j; w_dec.rd = w_inst[11:7]; w_wr = 1'b1;
                w_dec.rf_wr_sel = 2'b01; w_dec.alu_b_sel = 1'b1; w_dec.jump = 1'b1;
            end
            7'h67: begin                                   // jalr
                w_bad = (w_f3 != 3'd0);
                w_dec.imm = w_imm_i; w_dec.rs1 = w_inst[19:15]; w_dec.rd = w_inst[11:7];
                w_wr = 1'b1; w_dec.rf_wr_sel = 2'b01; w_dec.alu_a_sel = 1'b1;
                w_dec.alu_b_sel = 1'b1; w_dec.jump = 1'b1;
            end
            7'h63: begin                                   // branches compare via SUB
                w_dec.imm = w_imm_b; w_dec.rs1 = w_inst[19:15]; w_dec.rs2 = w_inst[24:20];
                w_dec.alu_a_sel = 1'b1; w_dec.alu_ctrl = ALU_SUB;
                case (w_f3)
                    3'd0: w_dec.br_type = 3'b001;
                    3'd1: w_dec.br_type = 3'b010;
                    3'd4: w_dec.br_type = 3'b011;
                    3'd5: w_dec.br_type = 3'b100;
                    3'd6: w_dec.br_type = 3'b101;
                    3'd7: w_dec.br_type = 3'b110;
                    default: w_bad = 1'b1;
                endcase
            end
            7'h03: begin                                   // loads
                w_dec.imm = w_imm_i; w_dec.rs1 = w_inst[19:15]; w_dec.rd = w_inst[11:7];
                w_wr = 1'b1; w_dec.rf_wr_sel = 2'b11; w_dec.alu_a_sel = 1'b1; w_dec.alu_b_sel = 1'b1;
                case (w_f3)
                    3'd0: w_dec.dm_rd_sel = 3'b001;
                    3'd4: w_dec.dm_rd_sel = 3'b010;
                    3'd1: w_dec.dm_rd_sel = 3'b011;
                    3'd5: w_dec.dm_rd_sel = 3'b100;
                    3'd2: w_dec.dm_rd_sel = 3'b101;
                    3'd6: if (IS64) w_dec.dm_rd_sel = 3'b110; else w_bad = 1'b1;
                    3'd3: if (IS64) w_dec.dm_rd_sel = 3'b111; else w_bad = 1'b1;
                    default: w_bad = 1'b1;
                endcase
            end
            7'h23: begin                                   // stores
                w_dec.imm = w_imm_s; w_dec.rs1 = w_inst[19:15]; w_dec.rs2 = w_inst[24:20];
                w_dec.alu_a_sel = 1'b1; w_dec.alu_b_sel = 1'b1;
                case (w_f3)
                    3'd0: w_dec.dm_wr_sel = 3'b001;
                    3'd1: w_dec.dm_wr_sel = 3'b010;
                    3'd2: w_dec.dm_wr_sel = 3'b011;
                    3'd3: if (IS64) w_dec.dm_wr_sel = 3'b100; else w_bad = 1'b1;
                    default: w_bad = 1'b1;
                endcase
            end
            7'h13: begin                                   // op-imm; shamt is 6 bits on RV64
                w_dec.imm = w_imm_i; w_dec.rs1 = w_inst[19:15]; w_dec.rd = w_inst[11:7];
                w_wr = 1'b1; w_dec.rf_wr_sel = 2'b10; w_dec.alu_a_sel = 1'b1; w_dec.alu_b_sel = 1'b1;
                w_dec.alu_ctrl = w_alu_rr;
                if (w_f3 == 3'd1)
                    w_bad = (w_inst[31:26] != 6'b000000) || (!IS64 && w_inst[25]);
                else if (w_f3 == 3'd5) begin
                    w_bad = ((w_inst[31:26] != 6'b000000) && (w_inst[31:26] != 6'b010000))
                            || (!IS64 && w_inst[25]);
                    w_dec.alu_ctrl = w_inst[30] ? ALU_SRA : ALU_SRL;
                end
            end
            7'h33: begin                                   // op
                w_dec.rs1 = w_inst[19:15]; w_dec.rs2 = w_inst[24:20]; w_dec.rd = w_inst[11:7];
                w_wr = 1'b1; w_dec.rf_wr_sel = 2'b10; w_dec.alu_a_sel = 1'b1;
                case (w_f7)
                    7'h00: w_dec.alu_ctrl = w_alu_rr;
                    7'h20: begin
                        if (w_f3 == 3'd0)      w_dec.alu_ctrl = ALU_SUB;
                        else if (w_f3 == 3'd5) w_dec.alu_ctrl = ALU_SRA;
                        else                   w_bad = 1'b1;
                    end
`ifdef YSYX_IDU_RVM_EN
                    7'h01: w_dec.alu_ctrl = {2'b10, w_f3};
`endif
                    default: w_bad = 1'b1;
                endcase
            end
            7'h1B: begin                                   // op-imm-32
                w_bad = !IS64;
                w_dec.imm = w_imm_i; w_dec.rs1 = w_inst[19:15]; w_dec.rd = w_inst[11:7];
                w_wr = 1'b1; w_dec.rf_wr_sel = 2'b10; w_dec.alu_a_sel = 1'b1; w_dec.alu_b_sel = 1'b1;
                w_dec.word = 1'b1;
                if (w_f3 == 3'd0)                           w_dec.alu_ctrl = ALU_ADD;
                else if (w_f3 == 3'd1 && w_f7 == 7'h00)     w_dec.alu_ctrl = ALU_SLL;
                else if (w_f3 == 3'd5 && w_f7 == 7'h00)     w_dec.alu_ctrl = ALU_SRL;
                else if (w_f3 == 3'd5 && w_f7 == 7'h20)     w_dec.alu_ctrl = ALU_SRA;
                else                                        w_bad = 1'b1;
            end
            7'h3B: begin                                   // op-32
                w_bad = !IS64;
                w_dec.rs1 = w_inst[19:15]; w_dec.rs2 = w_inst[24:20]; w_dec.rd = w_inst[11:7];
                w_wr = 1'b1; w_dec.rf_wr_sel = 2'b10; w_dec.alu_a_sel = 1'b1; w_dec.word = 1'b1;
                if (w_f7 == 7'h00 && w_f3 == 3'd0)          w_dec.alu_ctrl = ALU_ADD;
                else if (w_f7 == 7'h00 && w_f3 == 3'd1)     w_dec.alu_ctrl = ALU_SLL;
                else if (w_f7 == 7'h00 && w_f3 == 3'd5)     w_dec.alu_ctrl = ALU_SRL;
                else if (w_f7 == 7'h20 && w_f3 == 3'd0)     w_dec.alu_ctrl = ALU_SUB;
                else if (w_f7 == 7'h20 && w_f3 == 3'd5)     w_dec.alu_ctrl = ALU_SRA;
`ifdef YSYX_IDU_RVM_EN
                else if (w_f7 == 7'h01 && (w_f3 == 3'd0 || w_f3[2]))
                                                            w_dec.alu_ctrl = {2'b10, w_f3};
`endif
                else                                        w_bad = 1'b1;
            end
            7'h0F: w_bad = (w_f3 != 3'd0);                 // fence is a no-op here
            7'h73: begin
                if (w_inst == 32'h0000_0073)      w_dec.ecall  = 1'b1;
                else if (w_inst == 32'h0010_0073) w_dec.ebreak = 1'b1;
                else                              w_bad = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_dec         = '0;
            w_dec.pc      = bus.in_pc;
            w_dec.illegal = 1'b1;
        end else begin
            w_dec.rf_wr_en = w_wr && (w_dec.rd != 5'd0);
        end
    end

    assign w_m_vld    = (r_state != ST_EMPTY);
    assign w_in_ready = (r_state != ST_FULL);
    assign w_xfer_in  = bus.in_valid && w_in_ready;
    assign w_xfer_out = w_m_vld && bus.out_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Next occupancy and M/S load selects; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_ld_m_in   = 1'b0;
        w_ld_m_s    = 1'b0;
        w_ld_s_in   = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_xfer_in) begin
                    w_state_nxt = ST_ONE; w_ld_m_in = 1'b1;
                end
                ST_ONE: begin
                    if (w_xfer_in && w_xfer_out)  w_ld_m_in = 1'b1;
                    else if (w_xfer_in) begin w_state_nxt = ST_FULL; w_ld_s_in = 1'b1; end
                    else if (w_xfer_out)          w_state_nxt = ST_EMPTY;
                end
                ST_FULL: if (w_xfer_out) begin
                    w_state_nxt = ST_ONE; w_ld_m_s = 1'b1;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Bundle storage for main and skid entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            if (w_ld_m_in)     r_m <= w_dec;
            else if (w_ld_m_s) r_m <= r_s;
            if (w_ld_s_in)     r_s <= w_dec;
        end
    end

    // Side-effect fields read as zero during a bubble so stale M contents never leak
    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_m_vld;
    assign bus.out_pc        = r_m.pc;
    assign bus.out_imm       = r_m.imm;
    assign bus.out_rs1       = r_m.rs1;
    assign bus.out_rs2       = r_m.rs2;
    assign bus.out_rd        = r_m.rd;
    assign bus.out_rf_wr_en  = r_m.rf_wr_en & w_m_vld;
    assign bus.out_rf_wr_sel = r_m.rf_wr_sel;
    assign bus.out_alu_a_sel = r_m.alu_a_sel;
    assign bus.out_alu_b_sel = r_m.alu_b_sel;
    assign bus.out_alu_ctrl  = r_m.alu_ctrl;
    assign bus.out_word      = r_m.word;
    assign bus.out_dm_rd_sel = w_m_vld ? r_m.dm_rd_sel : 3'b000;
    assign bus.out_dm_wr_sel = w_m_vld ? r_m.dm_wr_sel : 3'b000;
    assign bus.out_br_type   = w_m_vld ? r_m.br_type : 3'b000;
    assign bus.out_jump      = r_m.jump & w_m_vld;
    assign bus.out_ebreak    = r_m.ebreak & w_m_vld;
    assign bus.out_ecall     = r_m.ecall & w_m_vld;
    assign bus.out_illegal   = r_m.illegal & w_m_vld;
endmodule

// File: tb/tb_ysyx_idu_pipe.sv
// tb_ysyx_idu_pipe: directed decode vectors, skid-buffer streaming, flush and reset.
module tb_ysyx_idu_pipe;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_idu_pipe_if #(.XLEN(XLEN)) bus();
    ysyx_idu_pipe #(.XLEN(XLEN)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int k, d;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'h0;
        bus.in_pc     = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_imm",       64'(bus.out_imm),   64'd0);
        chk("rst_alu",       64'(bus.out_alu_ctrl), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        bus.out_ready = 1'b1;
        issue(32'h0050_0093, 32'h8000_0000);               // addi x1,x0,5
        chk("addi_valid", 64'(bus.out_valid), 64'd1);
        chk("addi_pc",    64'(bus.out_pc),    64'h8000_0000);
        chk("addi_rd",    64'(bus.out_rd),    64'd1);
        chk("addi_imm",   64'(bus.out_imm),   64'd5);
        chk("addi_alu",   64'(bus.out_alu_ctrl), 64'd0);
        chk("addi_asel",  64'(bus.out_alu_a_sel), 64'd1);
        chk("addi_bsel",  64'(bus.out_alu_b_sel), 64'd1);
        chk("addi_wsel",  64'(bus.out_rf_wr_sel), 64'd2);
        chk("addi_wen",   64'(bus.out_rf_wr_en),  64'd1);

        issue(32'h0011_2223, 32'h8000_0004);               // sw x1,4(x2)
        chk("sw_dmwr", 64'(bus.out_dm_wr_sel), 64'd3);
        chk("sw_imm",  64'(bus.out_imm), 64'd4);
        chk("sw_rs1",  64'(bus.out_rs1), 64'd2);
        chk("sw_rs2",  64'(bus.out_rs2), 64'd1);
        chk("sw_wen",  64'(bus.out_rf_wr_en), 64'd0);

        issue(32'h0080_00EF, 32'h8000_0008);               // jal x1,8
        chk("jal_jump", 64'(bus.out_jump), 64'd1);
        chk("jal_imm",  64'(bus.out_imm), 64'd8);
        chk("jal_wsel", 64'(bus.out_rf_wr_sel), 64'd1);
        chk("jal_asel", 64'(bus.out_alu_a_sel), 64'd0);

        issue(32'h1234_50B7, 32'h8000_000C);               // lui x1,0x12345
        chk("lui_imm", 64'(bus.out_imm), 64'h1234_5000);
        chk("lui_alu", 64'(bus.out_alu_ctrl), 64'd14);

        issue(32'h0000_1117, 32'h8000_0010);               // auipc x2,1
        chk("auipc_asel", 64'(bus.out_alu_a_sel), 64'd0);
        chk("auipc_imm",  64'(bus.out_imm), 64'h1000);
        chk("auipc_rd",   64'(bus.out_rd), 64'd2);

        issue(32'hFE00_0EE3, 32'h8000_0014);               // beq x0,x0,-4
        chk("beq_imm",  64'(bus.out_imm), 64'hFFFF_FFFC);
        chk("beq_br",   64'(bus.out_br_type), 64'd1);
        chk("beq_alu",  64'(bus.out_alu_ctrl), 64'd1);
        chk("beq_bsel", 64'(bus.out_alu_b_sel), 64'd0);
        chk("beq_wen",  64'(bus.out_rf_wr_en), 64'd0);

        issue(32'h4020_81B3, 32'h8000_0018);               // sub x3,x1,x2
        chk("sub_alu", 64'(bus.out_alu_ctrl), 64'd1);
        chk("sub_imm", 64'(bus.out_imm), 64'd0);

        issue(32'h4033_5293, 32'h8000_001C);               // srai x5,x6,3
        chk("srai_alu", 64'(bus.out_alu_ctrl), 64'd7);

        issue(32'hFF83_2283, 32'h8000_0020);               // lw x5,-8(x6)
        chk("lw_dmrd", 64'(bus.out_dm_rd_sel), 64'd5);
        chk("lw_imm",  64'(bus.out_imm), 64'hFFFF_FFF8);
        chk("lw_wsel", 64'(bus.out_rf_wr_sel), 64'd3);

        issue(32'h0010_0013, 32'h8000_0024);               // addi x0,x0,1
        chk("rd0_wen", 64'(bus.out_rf_wr_en), 64'd0);

        issue(32'hFFFF_FFFF, 32'h8000_0028);
        chk("ill_flag", 64'(bus.out_illegal), 64'd1);
        chk("ill_wen",  64'(bus.out_rf_wr_en), 64'd0);
        chk("ill_dmwr", 64'(bus.out_dm_wr_sel), 64'd0);
        chk("ill_dmrd", 64'(bus.out_dm_rd_sel), 64'd0);
        chk("ill_jump", 64'(bus.out_jump), 64'd0);

        issue(32'h0010_0073, 32'h8000_002C);
        chk("ebreak", 64'(bus.out_ebreak), 64'd1);
        chk("ebreak_ill", 64'(bus.out_illegal), 64'd0);
        issue(32'h0000_0073, 32'h8000_0030);
        chk("ecall", 64'(bus.out_ecall), 64'd1);
        issue(32'h0020_0073, 32'h8000_0034);               // non-exact SYSTEM
        chk("sys_ill", 64'(bus.out_illegal), 64'd1);

        issue(32'h0000_B083, 32'h8000_0038);               // ld on RV32
        chk("ld32_ill",  64'(bus.out_illegal), 64'd1);
        chk("ld32_dmrd", 64'(bus.out_dm_rd_sel), 64'd0);

        issue(32'h0220_81B3, 32'h8000_003C);               // mul x3,x1,x2
`ifdef YSYX_IDU_RVM_EN
        chk("mul_alu", 64'(bus.out_alu_ctrl), 64'd16);
        chk("mul_rd",  64'(bus.out_rd), 64'd3);
        chk("mul_ill", 64'(bus.out_illegal), 64'd0);
`else
        chk("mul_ill", 64'(bus.out_illegal), 64'd1);
        chk("mul_wen", 64'(bus.out_rf_wr_en), 64'd0);
`endif
        step();
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // Four-instruction stream; EXU stalls for cycles 1..4
        k = 0;
        d = 0;
        for (int c = 0; c < 20 && d < 4; c++) begin
            bus.out_ready = !(c >= 1 && c < 5);
            bus.in_valid  = (k < 4);
            bus.in_inst   = {12'd0, 5'd0, 3'd0, 5'(k + 1), 7'h13};
            bus.in_pc     = 32'h1000 + 32'(4 * k);
            if (c == 2) chk("skid_full_ready", 64'(bus.in_ready), 64'd0);
            if (c == 4) chk("skid_hold_pc", 64'(bus.out_pc), 64'h1000);
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_pc", 64'(bus.out_pc), 64'(32'h1000 + 32'(4 * d)));
                chk("stream_rd", 64'(bus.out_rd), 64'(d + 1));
                d++;
            end
            if (bus.in_valid && bus.in_ready) k++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("stream_delivered", 64'(d), 64'd4);
        chk("stream_accepted",  64'(k), 64'd4);
        chk("stream_empty", 64'(bus.out_valid), 64'd0);

        // Fill both entries, then flush with a simultaneous offer
        bus.out_ready = 1'b0;
        issue(32'h0010_0093, 32'h2000);
        issue(32'h0020_0093, 32'h2004);
        chk("flush_pre_ready", 64'(bus.in_ready), 64'd0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0030_0093;
        bus.in_pc    = 32'h2008;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_wen",   64'(bus.out_rf_wr_en), 64'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("flush_ghost", 64'(bus.out_valid), 64'd0);
        end

        // Asynchronous reset while an entry is held
        bus.out_ready = 1'b0;
        issue(32'h0050_0093, 32'h3000);
        chk("prerst_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_rd",    64'(bus.out_rd), 64'd0);
        chk("arst_imm",   64'(bus.out_imm), 64'd0);
        chk("arst_pc",    64'(bus.out_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("postrst_ready", 64'(bus.in_ready), 64'd1);
        chk("postrst_valid", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
